// File: rtl/rr_grant_sched.sv
// Round-robin grant scheduler: holds a one-hot grant until done, request drop
// or hold timeout, then hands over back-to-back using a rotating priority mask.
module rr_grant_sched #(
    parameter int unsigned DATA_WIDTH = 5,
    parameter int unsigned HOLD_MAX   = 16,
    parameter int unsigned IDX_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_req,
    input  logic [DATA_WIDTH-1:0] i_done,
    output logic [DATA_WIDTH-1:0] o_grant,
    output logic                  o_gnt_vld,
    output logic [IDX_W-1:0]      o_gnt_idx,
    output logic                  o_busy,
    output logic                  o_timeout
);

    localparam int unsigned CNT_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] grant_q, grant_d;
    logic                  vld_q, vld_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  timeout_q, timeout_d;

    logic [DATA_WIDTH-1:0] cand;
    logic [DATA_WIDTH-1:0] lo_mask;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] pick;
    logic [IDX_W-1:0]      pick_idx;
    logic                  owner_done;
    logic                  owner_req;
    logic                  hold_to;
    logic                  load;

    // Candidates exclude the current owner while BUSY so it cannot re-win on release.
    always_comb begin
        cand     = (state_q == ST_IDLE) ? i_req : (i_req & ~grant_q);
        lo_mask  = (DATA_WIDTH'(1) << ptr_q) - DATA_WIDTH'(1);
        hi       = cand & ~lo_mask;
        pick     = (|hi) ? (hi & (~hi + DATA_WIDTH'(1)))
                         : (cand & (~cand + DATA_WIDTH'(1)));
        pick_idx = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (pick[i]) begin
                pick_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        vld_d      = vld_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
        load       = 1'b0;
        owner_done = |(i_done & grant_q);
        owner_req  = |(i_req & grant_q);
        hold_to    = (HOLD_MAX != 0) && (cnt_q == CNT_W'(HOLD_MAX - 1))
                     && !owner_done && owner_req;

        case (state_q)
            ST_IDLE: begin
                load = |cand;
            end
            ST_BUSY: begin
                if (owner_done || !owner_req || hold_to) begin
                    timeout_d = hold_to;
                    if (|cand) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        vld_d   = 1'b0;
                        idx_d   = '0;
                    end
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            state_d = ST_BUSY;
            grant_d = pick;
            vld_d   = 1'b1;
            idx_d   = pick_idx;
            cnt_d   = '0;
            ptr_d   = (pick_idx == IDX_W'(DATA_WIDTH - 1)) ? '0 : pick_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            vld_q     <= 1'b0;
            idx_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            vld_q     <= vld_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_grant   = grant_q;
    assign o_gnt_vld = vld_q;
    assign o_gnt_idx = idx_q;
    assign o_busy    = (state_q == ST_BUSY);
    assign o_timeout = timeout_q;

endmodule

// File: tb/tb_rr_grant_sched.sv
// Scoreboard bench for rr_grant_sched: the driver queues hand-computed
// per-cycle expectations, the monitor pops and compares after each edge.
module tb_rr_grant_sched;

    logic       clk;
    logic       rst_n;
    logic [4:0] req;
    logic [4:0] done;
    logic [4:0] grant;
    logic       gnt_vld;
    logic [2:0] gnt_idx;
    logic       busy;
    logic       tout;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0] grant;
        logic       tout;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    rr_grant_sched #(
        .DATA_WIDTH (5),
        .HOLD_MAX   (4)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (req),
        .i_done    (done),
        .o_grant   (grant),
        .o_gnt_vld (gnt_vld),
        .o_gnt_idx (gnt_idx),
        .o_busy    (busy),
        .o_timeout (tout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] idx_of(input logic [4:0] g);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (g[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic [4:0] r, input logic [4:0] d,
                        input logic [4:0] eg, input logic et, input string nm);
        exp_t e;
        req     = r;
        done    = d;
        e.grant = eg;
        e.tout  = et;
        e.name  = nm;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic check_zero(input string nm);
        n_checks++;
        if (grant !== 5'b0 || gnt_vld !== 1'b0 || gnt_idx !== 3'd0 ||
            busy !== 1'b0 || tout !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: grant=%b vld=%b idx=%0d busy=%b to=%b, expected all zero",
                     nm, grant, gnt_vld, gnt_idx, busy, tout);
        end
    endtask

    // Asynchronous reset asserted between edges, checked before the next edge.
    task automatic do_reset(input string nm);
        exp_t e;
        #2 rst_n = 1'b0;
        #1 check_zero(nm);
        req     = 5'b0;
        done    = 5'b0;
        e.grant = 5'b0;
        e.tout  = 1'b0;
        e.name  = {nm, "_held"};
        exp_q.push_back(e);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (grant !== e.grant || gnt_vld !== (|e.grant) ||
                    gnt_idx !== idx_of(e.grant) || busy !== (|e.grant) ||
                    tout !== e.tout) begin
                    n_fail++;
                    $display("FAIL %s: grant=%b idx=%0d vld=%b busy=%b to=%b, expected grant=%b idx=%0d vld=%b busy=%b to=%b",
                             e.name, grant, gnt_idx, gnt_vld, busy, tout,
                             e.grant, idx_of(e.grant), |e.grant, |e.grant, e.tout);
                end
            end
        end
    end

    initial begin : driver
        rst_n = 1'b0;
        req   = 5'b0;
        done  = 5'b0;
        #3 check_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // First grant and back-to-back handover on done
        step(5'b00110, 5'b00000, 5'b00010, 1'b0, "first_grant");
        step(5'b00110, 5'b00010, 5'b00100, 1'b0, "done_handover");
        step(5'b00110, 5'b00000, 5'b00100, 1'b0, "hold_after_handover");
        do_reset("reset_mid_grant_a");

        // Full rotation with done right after each grant
        step(5'b11111, 5'b00000, 5'b00001, 1'b0, "rot_0");
        step(5'b11111, 5'b00001, 5'b00010, 1'b0, "rot_1");
        step(5'b11111, 5'b00010, 5'b00100, 1'b0, "rot_2");
        step(5'b11111, 5'b00100, 5'b01000, 1'b0, "rot_3");
        step(5'b11111, 5'b01000, 5'b10000, 1'b0, "rot_4");
        step(5'b11111, 5'b10000, 5'b00001, 1'b0, "rot_wrap");
        step(5'b11111, 5'b00100, 5'b00001, 1'b0, "nonowner_done_all");

        // Owner drop is an implicit release without timeout
        step(5'b01001, 5'b00001, 5'b01000, 1'b0, "to_owner3");
        step(5'b00001, 5'b00000, 5'b00001, 1'b0, "owner3_drop");
        step(5'b00001, 5'b00100, 5'b00001, 1'b0, "nonowner_done2");
        step(5'b00000, 5'b00000, 5'b00000, 1'b0, "drop_to_idle");

        // Hold timeout at HOLD_MAX=4
        step(5'b00001, 5'b00000, 5'b00001, 1'b0, "to_c1");
        step(5'b00001, 5'b00000, 5'b00001, 1'b0, "to_c2");
        step(5'b00001, 5'b00000, 5'b00001, 1'b0, "to_c3");
        step(5'b00001, 5'b00000, 5'b00001, 1'b0, "to_c4");
        step(5'b00001, 5'b00000, 5'b00000, 1'b1, "timeout_revoke");
        step(5'b00001, 5'b00000, 5'b00001, 1'b0, "regrant_after_to");
        step(5'b00001, 5'b00000, 5'b00001, 1'b0, "d_c2");
        step(5'b00001, 5'b00000, 5'b00001, 1'b0, "d_c3");
        step(5'b00001, 5'b00000, 5'b00001, 1'b0, "d_c4");
        step(5'b00001, 5'b00001, 5'b00000, 1'b0, "done_beats_timeout");
        step(5'b00001, 5'b00000, 5'b00001, 1'b0, "regrant_after_done");

        // Reset mid-grant restarts the pointer at 0
        do_reset("reset_mid_grant_b");
        step(5'b10000, 5'b00000, 5'b10000, 1'b0, "post_reset_grant");
        step(5'b10000, 5'b00000, 5'b10000, 1'b0, "post_reset_hold");
        step(5'b00000, 5'b00000, 5'b00000, 1'b0, "final_idle");

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
